result_pipe_chain: RTL and testbench
====================================

# result_pipe_chain

Parametrised post-execute pipeline chain: a configurable-depth sequence of pipeline registers carrying execute results to register-file write-back. It generalises the fixed EXE→MEM→WB register pair: per-entry valid bit, whole-chain freeze, entry flush, load-data substitution at a configurable stage, and a two-port forwarding lookup with load-use hazard detection. It sits between the execute stage (upstream) and the register file / data memory (downstream).

## Interface
- WORD_LEN, 32: data width.
- REG_ADDR_LEN, 5: register address width.
- DEPTH, 2: number of register stages; legal values are DEPTH ≥ 2.
- LOAD_STAGE, 1: stage whose register captures memory read data; legal range is 1 ≤ LOAD_STAGE ≤ DEPTH-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- freeze  in  1  holds every stage and ignores the input entry.
- flush  in  1  inserts a bubble instead of the input entry.
- in_valid, in_wb_en, in_mem_r_en  in  1 each  attributes of the entry arriving from execute.
- in_dest  in  REG_ADDR_LEN  destination register.
- in_data  in  WORD_LEN  ALU result (memory address for loads).
- mem_ren  out  1  memory read strobe.
- mem_addr  out  WORD_LEN  data field of stage LOAD_STAGE-1.
- mem_rdata  in  WORD_LEN  combinational read data for mem_addr, valid in the same cycle.
- wb_valid, wb_en  out  1 each  valid and write-enable of stage DEPTH-1.
- wb_dest  out  REG_ADDR_LEN  destination of stage DEPTH-1.
- wb_data  out  WORD_LEN  data of stage DEPTH-1.
- src1, src2  in  REG_ADDR_LEN  lookup addresses from decode.
- fwd1_hit, fwd2_hit  out  1  a forwardable match exists.
- fwd1_data, fwd2_data  out  WORD_LEN  forwarded value; 0 when there is no hit.
- hazard  out  1  a load-use stall is required.
- retired  out  32  count of entries leaving stage DEPTH-1 with wb_en set.

## Operation
- Each stage s holds the fields {valid, wb_en, mem_r_en, dest, data}.
- Reset (rst=0 at an edge): all fields of every stage go to 0, and retired goes to 0. As a result, every output is 0 after reset.
- Priority at each edge is reset > freeze > flush > normal advance.
- Freeze: all stages and retired hold. A flush asserted in the same cycle has no effect.
- Normal advance:
  - Stage 0 captures the input fields. When flush=1, stage 0 captures valid=0 and all other fields 0.
  - Stage s (s ≥ 1) captures stage s-1.
  - Exception at stage LOAD_STAGE: if the incoming entry has valid & mem_r_en, its data field is taken from mem_rdata instead of the data field of stage LOAD_STAGE-1.
- mem_ren = stage[LOAD_STAGE-1].valid & mem_r_en & ~freeze.
- retired increments by 1 on an edge where freeze=0, rst=1, and stage DEPTH-1 has valid & wb_en. It wraps modulo 2^32.
- Forwarding lookup (combinational, evaluated independently for src1 and src2):
  - A stage matches when valid & wb_en & dest==src & src≠0.
  - The youngest (lowest-index) matching stage wins. Older matches are ignored.
  - If the winner has s < LOAD_STAGE and mem_r_en set, its data is not yet loaded: hit=0, data=0, and this port requests a stall.
  - Otherwise hit=1 and data = winner's data.
  - hazard = OR of the stall requests of both ports.
- The input entry itself is never a lookup candidate.
- Register 0 never hits and never raises a hazard.

## Timing
- Latency: an entry accepted at edge N appears on wb_* after edge N+DEPTH-1, provided there is no freeze. Each frozen cycle adds one cycle.
- Throughput: one entry per unfrozen cycle.
- A load's data is available for forwarding from the edge at which it enters stage LOAD_STAGE.
- The lookup outputs, mem_ren, mem_addr and the wb_* outputs are pure functions of the registered state and the current inputs. There is no extra register delay.
- wb_* remain stable while frozen. The downstream register file may rewrite the same value; that is harmless.
- Reset asserted mid-flight discards all in-flight entries at that edge. No write-back occurs for them, and retired is cleared.

## Test plan
- Reset and fill, defaults: hold rst=0 for 2 cycles → all outputs 0. Then push entries (dest 3, data 0x11), (dest 4, data 0x22) on consecutive cycles → wb shows dest 3 / 0x11 one edge after its accept and dest 4 / 0x22 on the next edge; retired ends at 2.
- Load substitution: DEPTH=3, LOAD_STAGE=2; push a load (dest 5, addr 0x40) with mem_rdata=0xCAFE whenever mem_addr=0x40 → mem_ren pulses for 1 cycle; wb_data=0xCAFE.
- Load-use hazard: load to r7 in stage 0 with LOAD_STAGE=1, src1=7 → hazard=1, fwd1_hit=0. After one advance → hazard=0, fwd1_hit=1, fwd1_data = the loaded value.
- Youngest-wins and r0: stage0 (dest 9, 0xAA), stage1 (dest 9, 0xBB), src2=9 → fwd2_data=0xAA. With src1=0 and a stage holding dest 0 → fwd1_hit=0.
- Freeze and flush: freeze for 3 cycles while asserting flush → state and retired are unchanged. Then flush=1 with in_valid=1 → the entry is dropped and is never retired.
- Reset mid-flight: two valid entries in flight and rst=0 for one edge → wb_valid=0 and retired=0 on the next cycle.

Source files
------------

// File: rtl/result_pipe_chain.sv
// result_pipe_chain: post-execute pipeline chain from execute to register-file
// write-back. It has a configurable number of stages, a per-entry valid bit,
// a whole-chain freeze, an entry flush, and load-data substitution at
// LOAD_STAGE. It also provides a two-port forwarding lookup with load-use
// hazard detection.
module result_pipe_chain #(
    parameter int unsigned WORD_LEN     = 32,
    parameter int unsigned REG_ADDR_LEN = 5,
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned LOAD_STAGE   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    freeze,
    input  logic                    flush,
    input  logic                    in_valid,
    input  logic                    in_wb_en,
    input  logic                    in_mem_r_en,
    input  logic [REG_ADDR_LEN-1:0] in_dest,
    input  logic [WORD_LEN-1:0]     in_data,
    output logic                    mem_ren,
    output logic [WORD_LEN-1:0]     mem_addr,
    input  logic [WORD_LEN-1:0]     mem_rdata,
    output logic                    wb_valid,
    output logic                    wb_en,
    output logic [REG_ADDR_LEN-1:0] wb_dest,
    output logic [WORD_LEN-1:0]     wb_data,
    input  logic [REG_ADDR_LEN-1:0] src1,
    input  logic [REG_ADDR_LEN-1:0] src2,
    output logic                    fwd1_hit,
    output logic                    fwd2_hit,
    output logic [WORD_LEN-1:0]     fwd1_data,
    output logic [WORD_LEN-1:0]     fwd2_data,
    output logic                    hazard,
    output logic [31:0]             retired
);

    logic                    stage_valid    [DEPTH];
    logic                    stage_wb_en    [DEPTH];
    logic                    stage_mem_r_en [DEPTH];
    logic [REG_ADDR_LEN-1:0] stage_dest     [DEPTH];
    logic [WORD_LEN-1:0]     stage_data     [DEPTH];

    logic stall1;
    logic stall2;

    // Stage registers and retire counter: reset > freeze > flush > advance.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned s = 0; s < DEPTH; s++) begin
                stage_valid[s]    <= 1'b0;
                stage_wb_en[s]    <= 1'b0;
                stage_mem_r_en[s] <= 1'b0;
                stage_dest[s]     <= '0;
                stage_data[s]     <= '0;
            end
            retired <= '0;
        end else if (!freeze) begin
            if (stage_valid[DEPTH-1] && stage_wb_en[DEPTH-1]) begin
                retired <= retired + 32'd1;
            end
            if (flush) begin
                stage_valid[0]    <= 1'b0;
                stage_wb_en[0]    <= 1'b0;
                stage_mem_r_en[0] <= 1'b0;
                stage_dest[0]     <= '0;
                stage_data[0]     <= '0;
            end else begin
                stage_valid[0]    <= in_valid;
                stage_wb_en[0]    <= in_wb_en;
                stage_mem_r_en[0] <= in_mem_r_en;
                stage_dest[0]     <= in_dest;
                stage_data[0]     <= in_data;
            end
            for (int unsigned s = 1; s < DEPTH; s++) begin
                stage_valid[s]    <= stage_valid[s-1];
                stage_wb_en[s]    <= stage_wb_en[s-1];
                stage_mem_r_en[s] <= stage_mem_r_en[s-1];
                stage_dest[s]     <= stage_dest[s-1];
                if (s == LOAD_STAGE && stage_valid[s-1] && stage_mem_r_en[s-1]) begin
                    stage_data[s] <= mem_rdata;
                end else begin
                    stage_data[s] <= stage_data[s-1];
                end
            end
        end
    end

    // Memory port and write-back view of the chain.
    always_comb begin
        mem_ren  = stage_valid[LOAD_STAGE-1] & stage_mem_r_en[LOAD_STAGE-1] & ~freeze;
        mem_addr = stage_data[LOAD_STAGE-1];
        wb_valid = stage_valid[DEPTH-1];
        wb_en    = stage_wb_en[DEPTH-1];
        wb_dest  = stage_dest[DEPTH-1];
        wb_data  = stage_data[DEPTH-1];
    end

    // Forwarding lookup. Stages are scanned oldest to youngest so that the
    // youngest match overwrites older ones. An unloaded load stalls instead of hitting.
    always_comb begin
        int unsigned idx;
        fwd1_hit  = 1'b0;
        fwd1_data = '0;
        stall1    = 1'b0;
        fwd2_hit  = 1'b0;
        fwd2_data = '0;
        stall2    = 1'b0;
        idx       = 0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = DEPTH - 1 - i;
            if (stage_valid[idx] && stage_wb_en[idx] && src1 != '0 && stage_dest[idx] == src1) begin
                if (idx < LOAD_STAGE && stage_mem_r_en[idx]) begin
                    fwd1_hit  = 1'b0;
                    fwd1_data = '0;
                    stall1    = 1'b1;
                end else begin
                    fwd1_hit  = 1'b1;
                    fwd1_data = stage_data[idx];
                    stall1    = 1'b0;
                end
            end
            if (stage_valid[idx] && stage_wb_en[idx] && src2 != '0 && stage_dest[idx] == src2) begin
                if (idx < LOAD_STAGE && stage_mem_r_en[idx]) begin
                    fwd2_hit  = 1'b0;
                    fwd2_data = '0;
                    stall2    = 1'b1;
                end else begin
                    fwd2_hit  = 1'b1;
                    fwd2_data = stage_data[idx];
                    stall2    = 1'b0;
                end
            end
        end
    end

    assign hazard = stall1 | stall2;

endmodule

// File: tb/tb_result_pipe_chain.sv
// Testbench for result_pipe_chain. A table of vectors drives a DEPTH=2,
// LOAD_STAGE=1 instance. A hand-written sequence exercises load substitution
// on a DEPTH=3, LOAD_STAGE=2 instance.
module tb_result_pipe_chain;

    logic        clk = 1'b0;
    logic        rst, freeze, flush, in_valid, in_wb_en, in_mem_r_en;
    logic [4:0]  in_dest, src1, src2;
    logic [31:0] in_data;

    logic        a_mem_ren, a_wb_valid, a_wb_en, a_h1, a_h2, a_hz;
    logic [31:0] a_mem_addr, a_rdata, a_wb_data, a_d1, a_d2, a_ret;
    logic [4:0]  a_wb_dest;
    logic        b_mem_ren, b_wb_valid, b_wb_en, b_h1, b_h2, b_hz;
    logic [31:0] b_mem_addr, b_rdata, b_wb_data, b_d1, b_d2, b_ret;
    logic [4:0]  b_wb_dest;

    int total = 0;
    int bad   = 0;

    // Free-running clock.
    always #5 clk = ~clk;

    // Memory model: a fixed word at 0x40; elsewhere the address plus 0x1000.
    assign a_rdata = (a_mem_addr == 32'h40) ? 32'hCAFE : a_mem_addr + 32'h1000;
    assign b_rdata = (b_mem_addr == 32'h40) ? 32'hCAFE : b_mem_addr + 32'h1000;

    result_pipe_chain #(.WORD_LEN(32), .REG_ADDR_LEN(5), .DEPTH(2), .LOAD_STAGE(1)) dut_a (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .in_valid(in_valid), .in_wb_en(in_wb_en), .in_mem_r_en(in_mem_r_en),
        .in_dest(in_dest), .in_data(in_data),
        .mem_ren(a_mem_ren), .mem_addr(a_mem_addr), .mem_rdata(a_rdata),
        .wb_valid(a_wb_valid), .wb_en(a_wb_en), .wb_dest(a_wb_dest), .wb_data(a_wb_data),
        .src1(src1), .src2(src2),
        .fwd1_hit(a_h1), .fwd2_hit(a_h2), .fwd1_data(a_d1), .fwd2_data(a_d2),
        .hazard(a_hz), .retired(a_ret)
    );

    result_pipe_chain #(.WORD_LEN(32), .REG_ADDR_LEN(5), .DEPTH(3), .LOAD_STAGE(2)) dut_b (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .in_valid(in_valid), .in_wb_en(in_wb_en), .in_mem_r_en(in_mem_r_en),
        .in_dest(in_dest), .in_data(in_data),
        .mem_ren(b_mem_ren), .mem_addr(b_mem_addr), .mem_rdata(b_rdata),
        .wb_valid(b_wb_valid), .wb_en(b_wb_en), .wb_dest(b_wb_dest), .wb_data(b_wb_data),
        .src1(src1), .src2(src2),
        .fwd1_hit(b_h1), .fwd2_hit(b_h2), .fwd1_data(b_d1), .fwd2_data(b_d2),
        .hazard(b_hz), .retired(b_ret)
    );

    // ctl = {rst, freeze, flush, valid, wb_en, mem_r_en}
    // ef  = expected {wb_valid(=wb_en), fwd1_hit, fwd2_hit, hazard, mem_ren}
    typedef struct packed {
        logic [5:0]  ctl;
        logic [4:0]  dest;
        logic [31:0] data;
        logic [4:0]  s1;
        logic [4:0]  s2;
        logic [4:0]  ef;
        logic [4:0]  e_dest;
        logic [31:0] e_data;
        logic [31:0] e_d1;
        logic [31:0] e_d2;
        logic [31:0] e_ret;
    } vec_t;

    vec_t tbl [25];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [5:0] ctl, input logic [4:0] d, input logic [31:0] dat,
                         input logic [4:0] a1, input logic [4:0] a2);
        {rst, freeze, flush, in_valid, in_wb_en, in_mem_r_en} = ctl;
        in_dest = d;
        in_data = dat;
        src1    = a1;
        src2    = a2;
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Bound on total run time.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{6'b100110, 5'd3,  32'h11,   5'd0,  5'd0, 5'b00000, 5'd0,  32'h0,    32'h0,    32'h0,  32'd0};
        tbl[1]  = '{6'b100110, 5'd4,  32'h22,   5'd3,  5'd4, 5'b01000, 5'd0,  32'h0,    32'h11,   32'h0,  32'd0};
        tbl[2]  = '{6'b100000, 5'd0,  32'h0,    5'd3,  5'd4, 5'b11100, 5'd3,  32'h11,   32'h11,   32'h22, 32'd0};
        tbl[3]  = '{6'b100000, 5'd0,  32'h0,    5'd4,  5'd0, 5'b11000, 5'd4,  32'h22,   32'h22,   32'h0,  32'd1};
        tbl[4]  = '{6'b100111, 5'd7,  32'h40,   5'd7,  5'd0, 5'b00000, 5'd0,  32'h0,    32'h0,    32'h0,  32'd2};
        tbl[5]  = '{6'b100000, 5'd0,  32'h0,    5'd7,  5'd7, 5'b00011, 5'd0,  32'h0,    32'h0,    32'h0,  32'd2};
        tbl[6]  = '{6'b100000, 5'd0,  32'h0,    5'd7,  5'd0, 5'b11000, 5'd7,  32'hCAFE, 32'hCAFE, 32'h0,  32'd2};
        tbl[7]  = '{6'b100110, 5'd9,  32'hBB,   5'd0,  5'd0, 5'b00000, 5'd0,  32'h0,    32'h0,    32'h0,  32'd3};
        tbl[8]  = '{6'b100110, 5'd9,  32'hAA,   5'd0,  5'd9, 5'b00100, 5'd0,  32'h0,    32'h0,    32'hBB, 32'd3};
        tbl[9]  = '{6'b100110, 5'd0,  32'h55,   5'd0,  5'd9, 5'b10100, 5'd9,  32'hBB,   32'h0,    32'hAA, 32'd3};
        tbl[10] = '{6'b100000, 5'd0,  32'h0,    5'd0,  5'd9, 5'b10100, 5'd9,  32'hAA,   32'h0,    32'hAA, 32'd4};
        tbl[11] = '{6'b111110, 5'd12, 32'h77,   5'd0,  5'd0, 5'b10000, 5'd0,  32'h55,   32'h0,    32'h0,  32'd5};
        tbl[12] = '{6'b111110, 5'd12, 32'h77,   5'd0,  5'd0, 5'b10000, 5'd0,  32'h55,   32'h0,    32'h0,  32'd5};
        tbl[13] = '{6'b111110, 5'd12, 32'h77,   5'd0,  5'd0, 5'b10000, 5'd0,  32'h55,   32'h0,    32'h0,  32'd5};
        tbl[14] = '{6'b101110, 5'd12, 32'h77,   5'd0,  5'd0, 5'b10000, 5'd0,  32'h55,   32'h0,    32'h0,  32'd5};
        tbl[15] = '{6'b100000, 5'd0,  32'h0,    5'd12, 5'd0, 5'b00000, 5'd0,  32'h0,    32'h0,    32'h0,  32'd6};
        tbl[16] = '{6'b100000, 5'd0,  32'h0,    5'd0,  5'd0, 5'b00000, 5'd0,  32'h0,    32'h0,    32'h0,  32'd6};
        tbl[17] = '{6'b100111, 5'd8,  32'h50,   5'd0,  5'd0, 5'b00000, 5'd0,  32'h0,    32'h0,    32'h0,  32'd6};
        tbl[18] = '{6'b110000, 5'd0,  32'h0,    5'd8,  5'd0, 5'b00010, 5'd0,  32'h0,    32'h0,    32'h0,  32'd6};
        tbl[19] = '{6'b100000, 5'd0,  32'h0,    5'd8,  5'd0, 5'b00011, 5'd0,  32'h0,    32'h0,    32'h0,  32'd6};
        tbl[20] = '{6'b100110, 5'd10, 32'h66,   5'd8,  5'd0, 5'b11000, 5'd8,  32'h1050, 32'h1050, 32'h0,  32'd6};
        tbl[21] = '{6'b100110, 5'd11, 32'h99,   5'd0,  5'd0, 5'b00000, 5'd0,  32'h0,    32'h0,    32'h0,  32'd7};
        tbl[22] = '{6'b000110, 5'd13, 32'h33,   5'd0,  5'd0, 5'b10000, 5'd10, 32'h66,   32'h0,    32'h0,  32'd7};
        tbl[23] = '{6'b100000, 5'd0,  32'h0,    5'd0,  5'd0, 5'b00000, 5'd0,  32'h0,    32'h0,    32'h0,  32'd0};
        tbl[24] = '{6'b100000, 5'd0,  32'h0,    5'd0,  5'd0, 5'b00000, 5'd0,  32'h0,    32'h0,    32'h0,  32'd0};

        // Reset for two cycles; every output of both instances must read 0.
        drive(6'b000000, 5'd0, 32'h0, 5'd0, 5'd0);
        step();
        step();
        drive(6'b100000, 5'd0, 32'h0, 5'd0, 5'd0);
        #1;
        chk("rst_a_wb_valid", {31'd0, a_wb_valid}, 32'd0);
        chk("rst_a_wb_en",    {31'd0, a_wb_en},    32'd0);
        chk("rst_a_wb_dest",  {27'd0, a_wb_dest},  32'd0);
        chk("rst_a_wb_data",  a_wb_data,           32'd0);
        chk("rst_a_mem_ren",  {31'd0, a_mem_ren},  32'd0);
        chk("rst_a_mem_addr", a_mem_addr,          32'd0);
        chk("rst_a_hazard",   {31'd0, a_hz},       32'd0);
        chk("rst_a_retired",  a_ret,               32'd0);
        chk("rst_b_wb_valid", {31'd0, b_wb_valid}, 32'd0);
        chk("rst_b_retired",  b_ret,               32'd0);

        // Table: check outputs before the edge, then clock the vector in.
        for (int i = 0; i < 25; i++) begin
            drive(tbl[i].ctl, tbl[i].dest, tbl[i].data, tbl[i].s1, tbl[i].s2);
            #1;
            chk($sformatf("v%0d_wb_valid", i), {31'd0, a_wb_valid}, {31'd0, tbl[i].ef[4]});
            chk($sformatf("v%0d_wb_en", i),    {31'd0, a_wb_en},    {31'd0, tbl[i].ef[4]});
            chk($sformatf("v%0d_wb_dest", i),  {27'd0, a_wb_dest},  {27'd0, tbl[i].e_dest});
            chk($sformatf("v%0d_wb_data", i),  a_wb_data,           tbl[i].e_data);
            chk($sformatf("v%0d_fwd1_hit", i), {31'd0, a_h1},       {31'd0, tbl[i].ef[3]});
            chk($sformatf("v%0d_fwd1_data", i), a_d1,               tbl[i].e_d1);
            chk($sformatf("v%0d_fwd2_hit", i), {31'd0, a_h2},       {31'd0, tbl[i].ef[2]});
            chk($sformatf("v%0d_fwd2_data", i), a_d2,               tbl[i].e_d2);
            chk($sformatf("v%0d_hazard", i),   {31'd0, a_hz},       {31'd0, tbl[i].ef[1]});
            chk($sformatf("v%0d_mem_ren", i),  {31'd0, a_mem_ren},  {31'd0, tbl[i].ef[0]});
            chk($sformatf("v%0d_retired", i),  a_ret,               tbl[i].e_ret);
            step();
        end

        // Load substitution on the 3-deep chain with the load captured at stage 2.
        drive(6'b000000, 5'd0, 32'h0, 5'd0, 5'd0);
        step();
        drive(6'b100111, 5'd5, 32'h40, 5'd5, 5'd0);
        #1;
        chk("b_ld0_mem_ren", {31'd0, b_mem_ren}, 32'd0);
        chk("b_ld0_hazard",  {31'd0, b_hz},      32'd0);
        step();
        drive(6'b100000, 5'd0, 32'h0, 5'd5, 5'd0);
        #1;
        chk("b_ld1_mem_ren", {31'd0, b_mem_ren}, 32'd0);
        chk("b_ld1_hazard",  {31'd0, b_hz},      32'd1);
        chk("b_ld1_fwd1_hit", {31'd0, b_h1},     32'd0);
        step();
        #1;
        chk("b_ld2_mem_ren",  {31'd0, b_mem_ren}, 32'd1);
        chk("b_ld2_mem_addr", b_mem_addr,         32'h40);
        chk("b_ld2_hazard",   {31'd0, b_hz},      32'd1);
        chk("b_ld2_wb_valid", {31'd0, b_wb_valid}, 32'd0);
        step();
        #1;
        chk("b_ld3_mem_ren",   {31'd0, b_mem_ren},  32'd0);
        chk("b_ld3_wb_valid",  {31'd0, b_wb_valid}, 32'd1);
        chk("b_ld3_wb_dest",   {27'd0, b_wb_dest},  32'd5);
        chk("b_ld3_wb_data",   b_wb_data,           32'hCAFE);
        chk("b_ld3_fwd1_hit",  {31'd0, b_h1},       32'd1);
        chk("b_ld3_fwd1_data", b_d1,                32'hCAFE);
        chk("b_ld3_hazard",    {31'd0, b_hz},       32'd0);
        chk("b_ld3_retired",   b_ret,               32'd0);
        step();
        #1;
        chk("b_ld4_wb_valid", {31'd0, b_wb_valid}, 32'd0);
        chk("b_ld4_retired",  b_ret,               32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
